// File: rtl/axil_reg4_pkg.sv
// Shared types and constants for the four-register AXI4-Lite slave.
// Imported by axil_reg4_wr_ctrl and axil_reg4_slave.
package axil_reg4_pkg;

  localparam int REG_NUM  = 4;
  localparam int REG_W    = 32;
  localparam int STRB_W   = REG_W / 8;
  localparam int ADDR_LSB = 2;
  localparam int IDX_W    = 2;
  // Byte offsets at or above this bit belong to no register.
  localparam int DEC_BITS = ADDR_LSB + IDX_W;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_COMMIT,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  // Byte-lane merge of a write into the current register value.
  function automatic logic [REG_W-1:0] apply_strb(
    input logic [REG_W-1:0]  old_val,
    input logic [REG_W-1:0]  new_val,
    input logic [STRB_W-1:0] strb
  );
    logic [REG_W-1:0] merged;
    merged = old_val;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) begin
        merged[8*b +: 8] = new_val[8*b +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/axil_reg4_wr_ctrl.sv
// Write-channel controller: captures AW and W independently, issues a one-cycle
// commit strobe with index/data/strobes, then holds the B response until accepted.
module axil_reg4_wr_ctrl
  import axil_reg4_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  output logic                  commit,
  output logic                  commit_err,
  output logic [IDX_W-1:0]      commit_idx,
  output logic [DATA_W-1:0]     commit_data,
  output logic [DATA_W/8-1:0]   commit_strb,
  output wr_state_t             state_dbg
);

  wr_state_t             state;
  wr_state_t             state_nx;
  logic                  aw_done;
  logic                  w_done;
  logic                  aw_hs;
  logic                  w_hs;
  logic [IDX_W-1:0]      idx_q;
  logic                  err_q;
  logic [DATA_W-1:0]     data_q;
  logic [DATA_W/8-1:0]   strb_q;
  resp_t                 bresp_q;
  logic                  unused_lsb;

  // Only the register index bits and the out-of-range flag are kept.
  assign unused_lsb = ^awaddr[ADDR_LSB-1:0];

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= W_IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
      strb_q  <= '0;
      bresp_q <= OKAY;
    end else begin
      state <= state_nx;
      if (aw_hs) begin
        aw_done <= 1'b1;
        idx_q   <= awaddr[ADDR_LSB +: IDX_W];
        err_q   <= |(awaddr >> DEC_BITS);
      end
      if (w_hs) begin
        w_done <= 1'b1;
        data_q <= wdata;
        strb_q <= wstrb;
      end
      // The response code is latched once and stays put for the whole B phase.
      if (state == W_COMMIT) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        bresp_q <= err_q ? SLVERR : OKAY;
      end
    end
  end

  always_comb begin
    state_nx = state;
    awready  = 1'b0;
    wready   = 1'b0;
    bvalid   = 1'b0;
    commit   = 1'b0;
    case (state)
      W_IDLE: begin
        awready = enable && !aw_done;
        wready  = enable && !w_done;
        if ((aw_done || (awvalid && awready)) && (w_done || (wvalid && wready))) begin
          state_nx = W_COMMIT;
        end
      end
      W_COMMIT: begin
        commit   = 1'b1;
        state_nx = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) begin
          state_nx = W_IDLE;
        end
      end
      default: state_nx = W_IDLE;
    endcase
  end

  assign bresp       = bresp_q;
  assign commit_err  = err_q;
  assign commit_idx  = idx_q;
  assign commit_data = data_q;
  assign commit_strb = strb_q;
  assign state_dbg   = state;

endmodule

// File: rtl/axil_reg4_slave.sv
// AXI4-Lite slave with four 32-bit registers at 0x0/0x4/0x8/0xC driving reg_out.
// Optional macro AXIL_REG4_WR_PULSE_EN adds a per-register write pulse output wr_pulse.
//
// Handshakes: a beat transfers on a rising edge where VALID and READY are both high;
// VALID never waits on READY, READY here depends only on registered state, and a
// raised VALID holds its payload stable until that transfer.
module axil_reg4_slave
  import axil_reg4_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 4,
  parameter logic [31:0] C_RESET_VAL        = 32'h0
) (
  input  logic                                   ACLK,
  input  logic                                   ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [REG_NUM-1:0][C_S_AXI_DATA_WIDTH-1:0] reg_out,
`ifdef AXIL_REG4_WR_PULSE_EN
  output logic [REG_NUM-1:0]                     wr_pulse,
`endif
  output wr_state_t                              wr_state_dbg,
  output rd_state_t                              rd_state_dbg
);

  logic [REG_NUM-1:0][C_S_AXI_DATA_WIDTH-1:0] regs;
  logic                                       live;
  logic                                       commit;
  logic                                       commit_err;
  logic [IDX_W-1:0]                           commit_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0]              commit_data;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]            commit_strb;
  rd_state_t                                  rd_state;
  rd_state_t                                  rd_state_nx;
  logic                                       ar_hs;
  logic                                       ar_err;
  logic [IDX_W-1:0]                           ar_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0]              rdata_q;
  resp_t                                      rresp_q;
  logic                                       unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[ADDR_LSB-1:0]};

  // Holds every READY low in the first cycle after reset release.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      live <= 1'b0;
    end else begin
      live <= 1'b1;
    end
  end

  axil_reg4_wr_ctrl #(
    .ADDR_W (C_S_AXI_ADDR_WIDTH),
    .DATA_W (C_S_AXI_DATA_WIDTH)
  ) u_wr_ctrl (
    .clk         (ACLK),
    .rst         (ARESET),
    .enable      (live),
    .awaddr      (S_AXI_AWADDR),
    .awvalid     (S_AXI_AWVALID),
    .awready     (S_AXI_AWREADY),
    .wdata       (S_AXI_WDATA),
    .wstrb       (S_AXI_WSTRB),
    .wvalid      (S_AXI_WVALID),
    .wready      (S_AXI_WREADY),
    .bresp       (S_AXI_BRESP),
    .bvalid      (S_AXI_BVALID),
    .bready      (S_AXI_BREADY),
    .commit      (commit),
    .commit_err  (commit_err),
    .commit_idx  (commit_idx),
    .commit_data (commit_data),
    .commit_strb (commit_strb),
    .state_dbg   (wr_state_dbg)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      regs <= {REG_NUM{C_RESET_VAL}};
    end else if (commit && !commit_err) begin
      regs[commit_idx] <= apply_strb(regs[commit_idx], commit_data, commit_strb);
    end
  end

  assign reg_out = regs;

`ifdef AXIL_REG4_WR_PULSE_EN
  // Fires for every in-range commit, including all-zero strobes.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_pulse <= '0;
    end else if (commit && !commit_err) begin
      wr_pulse <= REG_NUM'(1) << commit_idx;
    end else begin
      wr_pulse <= '0;
    end
  end
`endif

  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign ar_err = |(S_AXI_ARADDR >> DEC_BITS);
  assign ar_idx = S_AXI_ARADDR[ADDR_LSB +: IDX_W];

  // Sampling regs with a non-blocking read yields the pre-write value when
  // the AR handshake lands on the same edge as a commit.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rd_state <= R_IDLE;
      rdata_q  <= '0;
      rresp_q  <= OKAY;
    end else begin
      rd_state <= rd_state_nx;
      if (ar_hs) begin
        rdata_q <= ar_err ? '0 : regs[ar_idx];
        rresp_q <= ar_err ? SLVERR : OKAY;
      end
    end
  end

  always_comb begin
    rd_state_nx   = rd_state;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    case (rd_state)
      R_IDLE: begin
        S_AXI_ARREADY = live;
        if (S_AXI_ARVALID && live) begin
          rd_state_nx = R_DATA;
        end
      end
      R_DATA: begin
        S_AXI_RVALID = 1'b1;
        if (S_AXI_RREADY) begin
          rd_state_nx = R_IDLE;
        end
      end
      default: rd_state_nx = R_IDLE;
    endcase
  end

  assign S_AXI_RDATA  = rdata_q;
  assign S_AXI_RRESP  = rresp_q;
  assign rd_state_dbg = rd_state;

endmodule

// File: tb/tb_axil_reg4_slave.sv
// Bench for axil_reg4_slave (6-bit address so out-of-range offsets exist):
// vector table, hand-timed corner sequences and randomized traffic against a register model.
module tb_axil_reg4_slave;
  import axil_reg4_pkg::*;

  localparam int          AW      = 6;
  localparam logic [31:0] RST_VAL = 32'h0BAD_F00D;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]  awaddr;
  logic [2:0]     awprot;
  logic           awvalid;
  logic           awready;
  logic [31:0]    wdata;
  logic [3:0]     wstrb;
  logic           wvalid;
  logic           wready;
  logic [1:0]     bresp;
  logic           bvalid;
  logic           bready;
  logic [AW-1:0]  araddr;
  logic [2:0]     arprot;
  logic           arvalid;
  logic           arready;
  logic [31:0]    rdata;
  logic [1:0]     rresp;
  logic           rvalid;
  logic           rready;
  logic [3:0][31:0] reg_out;
`ifdef AXIL_REG4_WR_PULSE_EN
  logic [3:0]     wr_pulse;
`endif
  wr_state_t      wr_state_dbg;
  rd_state_t      rd_state_dbg;

  axil_reg4_slave #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (AW),
    .C_RESET_VAL        (RST_VAL)
  ) dut (
    .ACLK          (clk),
    .ARESET        (rst),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .reg_out       (reg_out),
`ifdef AXIL_REG4_WR_PULSE_EN
    .wr_pulse      (wr_pulse),
`endif
    .wr_state_dbg  (wr_state_dbg),
    .rd_state_dbg  (rd_state_dbg)
  );

  // ---------------- scoreboard / model ----------------
  int          checks;
  int          failures;
  logic [31:0] exp_q[$];
  logic [1:0]  exp_resp_q[$];
  logic [31:0] model_regs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: no handshake within cycle budget, expected one", name);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) model_regs[i] = RST_VAL;
  endtask

  task automatic model_write(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
    int a;
    a = int'(addr);
    if (a >= 16) begin
      resp = 2'b10;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model_regs[(a / 4) % 4][8*b +: 8] = data[8*b +: 8];
      end
      resp = 2'b00;
    end
  endtask

  task automatic model_read(input logic [AW-1:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
    int a;
    a = int'(addr);
    if (a >= 16) begin
      data = 32'h0;
      resp = 2'b10;
    end else begin
      data = model_regs[(a / 4) % 4];
      resp = 2'b00;
    end
  endtask

  task automatic check_regs(input string name);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_reg%0d", name, i), reg_out[i], model_regs[i]);
    end
  endtask

  // ---------------- driver tasks (all called at posedge+1) ----------------
  task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          input int b_dly, output logic [1:0] resp);
    int cyc;
    bit aw_done;
    bit w_done;
    bit aw_fire;
    bit w_fire;
    cyc = 0; aw_done = 0; w_done = 0; resp = 2'bxx;
    while (!(aw_done && w_done) && cyc < 100) begin
      awaddr  = addr;
      wdata   = data;
      wstrb   = strb;
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_fire) aw_done = 1;
      if (w_fire)  w_done  = 1;
      cyc++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    if (!(aw_done && w_done)) begin
      timeout_fail("write_addr_data");
      return;
    end
    repeat (b_dly) begin @(posedge clk); #1; end
    bready = 1'b1;
    cyc = 0;
    while (!bvalid && cyc < 100) begin @(posedge clk); #1; cyc++; end
    if (!bvalid) begin
      timeout_fail("write_resp");
      bready = 1'b0;
      return;
    end
    resp = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int ar_dly, input int r_dly,
                         output logic [31:0] data, output logic [1:0] resp);
    int cyc;
    bit done;
    bit fire;
    cyc = 0; done = 0; data = 32'hx; resp = 2'bxx;
    while (!done && cyc < 100) begin
      araddr  = addr;
      arvalid = (cyc >= ar_dly);
      fire    = arvalid && arready;
      @(posedge clk); #1;
      if (fire) done = 1;
      cyc++;
    end
    arvalid = 1'b0;
    if (!done) begin
      timeout_fail("read_addr");
      return;
    end
    repeat (r_dly) begin @(posedge clk); #1; end
    rready = 1'b1;
    cyc = 0;
    while (!rvalid && cyc < 100) begin @(posedge clk); #1; cyc++; end
    if (!rvalid) begin
      timeout_fail("read_data");
      rready = 1'b0;
      return;
    end
    data = rdata;
    resp = rresp;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          is_wr;
    logic [AW-1:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input bit is_wr, input logic [AW-1:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [31:0] exp_rdata,
                         input logic [1:0] exp_resp);
    vec_t v;
    v.is_wr = is_wr; v.addr = addr; v.data = data; v.strb = strb;
    v.exp_rdata = exp_rdata; v.exp_resp = exp_resp;
    vecs.push_back(v);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation still running at 2 ms, expected to finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [1:0]  resp;
    logic [1:0]  mresp;
    logic [31:0] data;
    logic [31:0] old_val;
    checks = 0; failures = 0;
    rst = 1'b1;
    awaddr = '0; awprot = 3'b0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = 3'b0; arvalid = 1'b0; rready = 1'b0;
    model_reset();

    // reset state
    #12;
    check("rst_awready", 32'(awready), 32'h0);
    check("rst_wready",  32'(wready),  32'h0);
    check("rst_arready", 32'(arready), 32'h0);
    check("rst_bvalid",  32'(bvalid),  32'h0);
    check("rst_rvalid",  32'(rvalid),  32'h0);
    check("rst_bresp",   32'(bresp),   32'h0);
    check("rst_rresp",   32'(rresp),   32'h0);
    check("rst_rdata",   rdata,        32'h0);
    check_regs("rst");
    #10 rst = 1'b0;
    #1;
    check("rel_awready_low", 32'(awready), 32'h0);
    @(posedge clk); #1;
    check("rel_awready", 32'(awready), 32'h1);
    check("rel_wready",  32'(wready),  32'h1);
    check("rel_arready", 32'(arready), 32'h1);

    // table: basic writes/readback, strobes, zero strobe, out-of-range
    add_vec(1, 6'h00, 32'h0000_0001, 4'hF, 32'h0, 2'b00);
    add_vec(1, 6'h04, 32'h0000_0002, 4'hF, 32'h0, 2'b00);
    add_vec(1, 6'h08, 32'h0000_0003, 4'hF, 32'h0, 2'b00);
    add_vec(1, 6'h0C, 32'h0000_0004, 4'hF, 32'h0, 2'b00);
    add_vec(0, 6'h00, 32'h0, 4'h0, 32'h0000_0001, 2'b00);
    add_vec(0, 6'h04, 32'h0, 4'h0, 32'h0000_0002, 2'b00);
    add_vec(0, 6'h08, 32'h0, 4'h0, 32'h0000_0003, 2'b00);
    add_vec(0, 6'h0C, 32'h0, 4'h0, 32'h0000_0004, 2'b00);
    add_vec(1, 6'h04, 32'h1122_3344, 4'hF, 32'h0, 2'b00);
    add_vec(1, 6'h04, 32'hAABB_CCDD, 4'h5, 32'h0, 2'b00);
    add_vec(0, 6'h04, 32'h0, 4'h0, 32'h11BB_33DD, 2'b00);
    add_vec(1, 6'h04, 32'hFFFF_FFFF, 4'h0, 32'h0, 2'b00);
    add_vec(0, 6'h04, 32'h0, 4'h0, 32'h11BB_33DD, 2'b00);
    add_vec(1, 6'h0C, 32'hCAFE_F00D, 4'hA, 32'h0, 2'b00);
    add_vec(0, 6'h0C, 32'h0, 4'h0, 32'hCA00_F004, 2'b00);
    add_vec(1, 6'h20, 32'h1234_5678, 4'hF, 32'h0, 2'b10);
    add_vec(0, 6'h20, 32'h0, 4'h0, 32'h0, 2'b10);
    add_vec(1, 6'h3C, 32'hFFFF_FFFF, 4'hF, 32'h0, 2'b10);
    add_vec(0, 6'h11, 32'h0, 4'h0, 32'h0, 2'b10);
    add_vec(0, 6'h06, 32'h0, 4'h0, 32'h11BB_33DD, 2'b00);
    add_vec(0, 6'h08, 32'h0, 4'h0, 32'h0000_0003, 2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, 0, resp);
        check($sformatf("tbl%0d_bresp", i), 32'(resp), 32'(vecs[i].exp_resp));
        model_write(vecs[i].addr, vecs[i].data, vecs[i].strb, mresp);
        check_regs($sformatf("tbl%0d", i));
      end else begin
        do_read(vecs[i].addr, 0, 0, data, resp);
        check($sformatf("tbl%0d_rdata", i), data, vecs[i].exp_rdata);
        check($sformatf("tbl%0d_rresp", i), 32'(resp), 32'(vecs[i].exp_resp));
      end
    end

    // W leads AW by three cycles; BVALID two cycles after the AW handshake
    wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
    check("wfirst_wready", 32'(wready), 32'h1);
    @(posedge clk); #1;
    wvalid = 1'b0;
    check("wfirst_wready_held_low", 32'(wready), 32'h0);
    check("wfirst_awready", 32'(awready), 32'h1);
    repeat (2) begin @(posedge clk); #1; end
    awaddr = 6'h08; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    check("wfirst_bvalid_commit", 32'(bvalid), 32'h0);
    check("wfirst_awready_commit", 32'(awready), 32'h0);
    @(posedge clk); #1;
    check("wfirst_bvalid", 32'(bvalid), 32'h1);
    check("wfirst_bresp", 32'(bresp), 32'h0);
    model_write(6'h08, 32'hDEAD_BEEF, 4'hF, mresp);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("wfirst_bvalid_done", 32'(bvalid), 32'h0);
    repeat (3) begin @(posedge clk); #1; end
    check("wfirst_single_commit", 32'(bvalid), 32'h0);
    check("wfirst_state", 32'(wr_state_dbg), 32'(W_IDLE));
    check_regs("wfirst");

    // B and R back-pressure
    awaddr = 6'h00; wdata = 32'h5555_AAAA; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(posedge clk); #1;
    model_write(6'h00, 32'h5555_AAAA, 4'hF, mresp);
    for (int c = 0; c < 10; c++) begin
      check($sformatf("bp_bvalid_c%0d", c), 32'(bvalid), 32'h1);
      check($sformatf("bp_bresp_c%0d", c), 32'(bresp), 32'h0);
      check($sformatf("bp_awready_c%0d", c), 32'(awready), 32'h0);
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("bp_bvalid_done", 32'(bvalid), 32'h0);
    araddr = 6'h00; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check($sformatf("bp_rvalid_c%0d", c), 32'(rvalid), 32'h1);
      check($sformatf("bp_rdata_c%0d", c), rdata, 32'h5555_AAAA);
      check($sformatf("bp_arready_c%0d", c), 32'(arready), 32'h0);
      @(posedge clk); #1;
    end
    check("bp_rd_state", 32'(rd_state_dbg), 32'(R_DATA));
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check("bp_rvalid_done", 32'(rvalid), 32'h0);

    // AR handshake on the commit edge of a write to the same register
    old_val = model_regs[1];
    awaddr = 6'h04; wdata = 32'h0F0F_0F0F; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 6'h04; arvalid = 1'b1;
    check("conflict_arready", 32'(arready), 32'h1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    model_write(6'h04, 32'h0F0F_0F0F, 4'hF, mresp);
    check("conflict_rdata_old", rdata, old_val);
    check("conflict_reg_new", reg_out[1], 32'h0F0F_0F0F);
`ifdef AXIL_REG4_WR_PULSE_EN
    check("conflict_wr_pulse", 32'(wr_pulse), 32'h2);
`endif
    check("conflict_bvalid", 32'(bvalid), 32'h1);
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;
`ifdef AXIL_REG4_WR_PULSE_EN
    check("conflict_wr_pulse_clear", 32'(wr_pulse), 32'h0);
`endif

    // reset between AW and W handshakes
    awaddr = 6'h08; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    #3 rst = 1'b1;
    #1;
    model_reset();
    check("midrst_awready", 32'(awready), 32'h0);
    check("midrst_wready", 32'(wready), 32'h0);
    check("midrst_bvalid", 32'(bvalid), 32'h0);
    check("midrst_state", 32'(wr_state_dbg), 32'(W_IDLE));
    check_regs("midrst");
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("midrst_rel_low", 32'(wready), 32'h0);
    @(posedge clk); #1;
    check("midrst_rel_awready", 32'(awready), 32'h1);
    wdata = 32'h0000_0077; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("midrst_no_bvalid", 32'(bvalid), 32'h0);
    check_regs("midrst_w_only");
    awaddr = 6'h00; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(posedge clk); #1;
    check("midrst_new_bvalid", 32'(bvalid), 32'h1);
    check("midrst_new_bresp", 32'(bresp), 32'h0);
    model_write(6'h00, 32'h0000_0077, 4'hF, mresp);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check_regs("midrst_new");

    // randomized traffic with random channel skew and back-pressure
    for (int n = 0; n < 150; n++) begin
      logic [AW-1:0] a;
      logic [31:0]   d;
      logic [3:0]    s;
      logic [31:0]   exp_d;
      logic [1:0]    exp_r;
      if ($urandom_range(0, 3) == 0) a = AW'($urandom_range(16, 63));
      else                           a = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom();
        s = 4'($urandom_range(0, 15));
        do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), resp);
        model_write(a, d, s, exp_r);
        check($sformatf("rnd%0d_bresp", n), 32'(resp), 32'(exp_r));
        check_regs($sformatf("rnd%0d", n));
      end else begin
        model_read(a, exp_d, exp_r);
        exp_q.push_back(exp_d);
        exp_resp_q.push_back(exp_r);
        do_read(a, $urandom_range(0, 3), $urandom_range(0, 3), data, resp);
        check($sformatf("rnd%0d_rdata", n), data, exp_q.pop_front());
        check($sformatf("rnd%0d_rresp", n), 32'(resp), 32'(exp_resp_q.pop_front()));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
